// File: rtl/if_id_pkg.sv
// Shared types for the IF->ID stage register: payload layout, occupancy states
// and the default bubble instruction.
package if_id_pkg;

    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] inst;
    } if_id_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } if_id_state_e;

endpackage

// File: rtl/if_id_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage's performance-debug statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF->ID pipeline register with valid/ready handshake, optional skid entry
// (registered in_ready), flush-to-bubble and saturating stall/flush counters.
module if_id_stage_reg
    import if_id_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEFAULT_NOP_INST),
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc_plus_4,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc_plus_4,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef struct packed {
        logic [PC_W-1:0]   pc_plus_4;
        logic [INST_W-1:0] inst;
    } payload_t;

    if_id_state_e state_p1;
    if_id_state_e state_d;
    payload_t     main_p1;
    payload_t     skid_p1;
    payload_t     in_pay;
    logic         in_ready_p1;
    logic         vld_p1;
    logic         in_fire;
    logic         out_fire;
    logic         main_ld_in;
    logic         main_ld_skid;
    logic         skid_ld;
    logic         stall_inc;

    assign in_pay   = {in_pc_plus_4, in_inst};
    assign vld_p1   = (state_p1 != EMPTY);
    // Without a skid entry the only room for a new beat is the one leaving this cycle.
    assign in_ready = (SKID != 0) ? in_ready_p1 : (!vld_p1 || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p1 && out_ready;

    // ---- stage boundary: occupancy state ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1    <= EMPTY;
            in_ready_p1 <= 1'b1;
        end else begin
            state_p1    <= state_d;
            in_ready_p1 <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d      = state_p1;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (in_fire) begin
                        state_d    = ONE;
                        main_ld_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld_in = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d      = ONE;
                        main_ld_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ---- stage boundary: payload entries (qualified by state, so no reset) ----
    always_ff @(posedge clk) begin
        if (main_ld_in) begin
            main_p1 <= in_pay;
        end else if (main_ld_skid) begin
            main_p1 <= skid_p1;
        end
        if (skid_ld) begin
            skid_p1 <= in_pay;
        end
    end

    always_comb begin
        out_valid     = vld_p1;
        out_pc_plus_4 = '0;
        out_inst      = NOP_INST;
        if (vld_p1) begin
            out_pc_plus_4 = main_p1.pc_plus_4;
            out_inst      = main_p1.inst;
        end
    end

    assign stall_inc = vld_p1 && !out_ready && !flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg: skid, no-skid and narrow-counter instances,
// scoreboarded payload ordering plus reset, flush and saturation checks.
module tb_if_id_stage_reg;
    import if_id_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SKID=1, CNT_W=16
    logic        fl = 1'b0, iv = 1'b0, ordy = 1'b0, ir, ov;
    logic [31:0] ip = '0, ii = '0, opc, oi;
    logic [15:0] stall, fcnt;
    // SKID=0
    logic        iv0 = 1'b0, ordy0 = 1'b0, ir0, ov0;
    logic [31:0] ip0 = '0, ii0 = '0, opc0, oi0;
    logic [15:0] stall0, fcnt0;
    // SKID=1, CNT_W=4
    logic        iv4 = 1'b0, ordy4 = 1'b0, ir4, ov4;
    logic [31:0] ip4 = '0, ii4 = '0, opc4, oi4;
    logic [3:0]  stall4, fcnt4;

    if_id_payload_t q1[$];
    if_id_payload_t q0[$];

    if_id_stage_reg #(.SKID(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(ir),
        .in_pc_plus_4(ip), .in_inst(ii), .out_valid(ov), .out_ready(ordy),
        .out_pc_plus_4(opc), .out_inst(oi), .stall_cycles(stall), .flush_count(fcnt)
    );

    if_id_stage_reg #(.SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv0), .in_ready(ir0),
        .in_pc_plus_4(ip0), .in_inst(ii0), .out_valid(ov0), .out_ready(ordy0),
        .out_pc_plus_4(opc0), .out_inst(oi0), .stall_cycles(stall0), .flush_count(fcnt0)
    );

    if_id_stage_reg #(.SKID(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv4), .in_ready(ir4),
        .in_pc_plus_4(ip4), .in_inst(ii4), .out_valid(ov4), .out_ready(ordy4),
        .out_pc_plus_4(opc4), .out_inst(oi4), .stall_cycles(stall4), .flush_count(fcnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the handshakes just before the rising edge, return at the falling edge.
    task automatic tick();
        if_id_payload_t e;
        #1;
        if (fl) begin
            q1.delete();
        end else begin
            if (ov && ordy) begin
                if (q1.size() == 0) begin
                    chk("sb1_extra_beat", 64'(q1.size()), 64'd1);
                end else begin
                    e = q1.pop_front();
                    chk("sb1_pc", 64'(opc), 64'(e.pc_plus_4));
                    chk("sb1_inst", 64'(oi), 64'(e.inst));
                end
            end
            if (iv && ir) q1.push_back('{pc_plus_4: ip, inst: ii});
        end
        if (ov0 && ordy0) begin
            if (q0.size() == 0) begin
                chk("sb0_extra_beat", 64'(q0.size()), 64'd1);
            end else begin
                e = q0.pop_front();
                chk("sb0_pc", 64'(opc0), 64'(e.pc_plus_4));
                chk("sb0_inst", 64'(oi0), 64'(e.inst));
            end
        end
        if (iv0 && ir0) q0.push_back('{pc_plus_4: ip0, inst: ii0});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        iv = v;
        ip = pc;
        ii = inst;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] insts [3];
        logic        exp_ir0 [4];
        insts   = '{32'h8C01_0000, 32'h8C02_0004, 32'h0022_1820};
        exp_ir0 = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_in_ready", 64'(ir), 64'd1);
        chk("rst_out_inst", 64'(oi), 64'h0);
        chk("rst_out_pc", 64'(opc), 64'h0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_flush_cnt", 64'(fcnt), 64'd0);
        rst = 1'b0;

        // Streaming with out_ready high: one-cycle latency, in_ready stays high
        ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(4 * (k + 1)), insts[k]);
            tick();
            chk("stream_out_valid", 64'(ov), 64'd1);
            chk("stream_out_pc", 64'(opc), 64'(4 * (k + 1)));
            chk("stream_in_ready", 64'(ir), 64'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("stream_drained", 64'(q1.size()), 64'd0);
        chk("stream_idle_valid", 64'(ov), 64'd0);

        // Backpressure: fill main + skid, hold first beat
        ordy = 1'b0;
        drive(1'b1, 32'd16, 32'hAAAA_0010);
        tick();
        drive(1'b1, 32'd20, 32'hAAAA_0014);
        tick();
        chk("bp_in_ready_full", 64'(ir), 64'd0);
        drive(1'b1, 32'd24, 32'hAAAA_0018);
        tick();
        tick();
        chk("bp_hold_pc", 64'(opc), 64'd16);
        chk("bp_hold_inst", 64'(oi), 64'hAAAA_0010);
        chk("bp_stall_cycles", 64'(stall), 64'd3);
        chk("bp_in_ready_still0", 64'(ir), 64'd0);
        drive(1'b0, 32'h0, 32'h0);
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) if (q1.size() != 0) tick();
        chk("bp_drained", 64'(q1.size()), 64'd0);
        tick();
        chk("bp_no_extra", 64'(ov), 64'd0);

        // Flush while FULL with a beat offered
        ordy = 1'b0;
        drive(1'b1, 32'd28, 32'hBBBB_001C);
        tick();
        drive(1'b1, 32'd32, 32'hBBBB_0020);
        tick();
        drive(1'b1, 32'd36, 32'hBBBB_0024);
        fl = 1'b1;
        tick();
        fl = 1'b0;
        chk("flush_out_valid", 64'(ov), 64'd0);
        chk("flush_out_inst", 64'(oi), 64'h0);
        chk("flush_out_pc", 64'(opc), 64'h0);
        chk("flush_count_1", 64'(fcnt), 64'd1);
        chk("flush_stall_masked", 64'(stall), 64'd4);
        chk("flush_in_ready", 64'(ir), 64'd1);
        drive(1'b0, 32'h0, 32'h0);
        ordy = 1'b1;
        tick();
        tick();
        chk("flush_nothing_emitted", 64'(ov), 64'd0);

        // Flush while EMPTY: the accepted beat is dropped
        drive(1'b1, 32'd40, 32'hCCCC_0028);
        fl = 1'b1;
        #1;
        chk("flush_empty_in_ready", 64'(ir), 64'd1);
        tick();
        fl = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_empty_dropped", 64'(ov), 64'd0);
        chk("flush_count_2", 64'(fcnt), 64'd2);

        // SKID=0: combinational in_ready, every accepted beat emitted once
        iv0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ordy0 = k[0] ? 1'b0 : 1'b1;
            ip0 = 32'(100 + 4 * k);
            ii0 = 32'hD000_0000 + 32'(k);
            #1;
            chk("skid0_in_ready", 64'(ir0), 64'(exp_ir0[k]));
            tick();
        end
        iv0 = 1'b0;
        ordy0 = 1'b1;
        for (int i = 0; i < 6; i++) if (q0.size() != 0) tick();
        chk("skid0_drained", 64'(q0.size()), 64'd0);

        // Asynchronous reset between edges while FULL
        ordy = 1'b0;
        drive(1'b1, 32'd44, 32'hEEEE_002C);
        tick();
        drive(1'b1, 32'd48, 32'hEEEE_0030);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("pre_reset_full", 64'(ir), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(ov), 64'd0);
        chk("async_rst_in_ready", 64'(ir), 64'd1);
        chk("async_rst_inst", 64'(oi), 64'h0);
        chk("async_rst_pc", 64'(opc), 64'h0);
        chk("async_rst_stall", 64'(stall), 64'd0);
        chk("async_rst_flush_cnt", 64'(fcnt), 64'd0);
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        ordy = 1'b1;
        drive(1'b1, 32'd52, 32'hF000_0034);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("post_rst_first_accept", 64'(ov), 64'd1);
        tick();
        chk("post_rst_drained", 64'(q1.size()), 64'd0);

        // CNT_W=4: stall counter saturates at 15
        ordy4 = 1'b0;
        iv4 = 1'b1;
        ip4 = 32'd60;
        ii4 = 32'h1234_5678;
        tick();
        iv4 = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_stall_14", 64'(stall4), 64'd14);
        for (int i = 0; i < 7; i++) tick();
        chk("sat_stall_15", 64'(stall4), 64'd15);
        chk("sat_hold_pc", 64'(opc4), 64'd60);
        chk("sat_flush_cnt", 64'(fcnt4), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
# if_id_stage_reg

Parametrised IF→ID pipeline stage register carrying the PC+4 and the fetched instruction from fetch to decode. Unlike a plain clocked register it uses a valid/ready handshake, holds its output under decode backpressure, and absorbs one extra beat in an optional skid entry so `in_ready` is registered. On flush (branch redirect) it drops its contents and presents a NOP bubble. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `PC_W`, 32, width of PC+4 field
- `INST_W`, 32, instruction width
- `NOP_INST`, `32'h0000_0000`, instruction driven when no valid beat is held
- `SKID`, 1, 1 = two-entry (main + skid) with registered `in_ready`; 0 = single entry, combinational `in_ready`
- `CNT_W`, 16, width of performance counters

Ports:
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous, active-high reset
- `flush` in 1, discard all held and incoming beats this cycle
- `in_valid` in 1, fetch presents a beat
- `in_ready` out 1, stage accepts a beat
- `in_pc_plus_4` in PC_W, fetch PC+4
- `in_inst` in INST_W, fetched instruction
- `out_valid` out 1, decode beat valid
- `out_ready` in 1, decode accepts
- `out_pc_plus_4` out PC_W, registered PC+4
- `out_inst` out INST_W, registered instruction (`NOP_INST` when `!out_valid`)
- `stall_cycles` out CNT_W, count of cycles with `out_valid && !out_ready`
- `flush_count` out CNT_W, count of cycles with `flush` high

## Operation
- Definitions: in_fire = `in_valid && in_ready`; out_fire = `out_valid && out_ready`.
- SKID=1 states: EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
  - EMPTY: in_fire → ONE; main loads input.
  - ONE: in_fire && out_fire → ONE, main loads input. in_fire only → FULL, skid loads input. out_fire only → EMPTY.
  - FULL: `in_ready`=0. out_fire → ONE, main loads skid. Otherwise hold.
  - `in_ready` = registered (state != FULL).
- SKID=0: single main entry, `in_ready` = `!out_valid || out_ready`. Main loads on in_fire. Clears on out_fire without in_fire.
- `flush` has top priority. Next state is EMPTY. `out_valid`=0, `out_inst`=`NOP_INST`, `out_pc_plus_4`=0. A beat accepted in the flush cycle is dropped. The upstream handshake still completes.
- Output payload stays stable while `out_valid && !out_ready`. No beat is duplicated, reordered, or lost except by flush.
- Counters saturate at all-ones and do not wrap. A stall cycle is not counted when `flush` is high in the same cycle.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N, if the stage was EMPTY or draining.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Reset (async, while `rst`=1):
  - state EMPTY
  - `out_valid`=0
  - `in_ready`=1 (SKID=1)
  - `out_inst`=`NOP_INST`
  - `out_pc_plus_4`=0
  - both counters 0
- Reset asserted mid-transfer drops all entries with no partial update. The first accept is possible on the first edge after `rst` deasserts.
- Simultaneous in_fire + out_fire in FULL cannot occur, because `in_ready`=0 in FULL.

## Structure
- Package `if_id_pkg`:
  - `if_id_payload_t` struct {pc_plus_4, inst}
  - `if_id_state_e` enum {EMPTY, ONE, FULL}
  - default `NOP_INST` constant
- Sub-module `sat_counter` (params W; inputs `clk`, `rst`, `inc`; output `count`), instantiated twice for the counters.

## Test plan
- Reset then stream PC+4 = 4, 8, 12 with instructions `0x8C010000`, `0x8C020004`, `0x00221820`, `out_ready`=1 → outputs appear one cycle later in order. `in_ready` stays 1.
- `out_ready`=0 for 3 cycles during stream (SKID=1) → state reaches FULL, `in_ready` drops after 2 accepted beats, `out_*` holds the first beat, `stall_cycles`=3. Releasing `out_ready` drains both beats in order with no loss.
- `flush` in FULL with `in_valid`=1 → next cycle `out_valid`=0, `out_inst`=`0x00000000`, `out_pc_plus_4`=0, `flush_count`=1. The concurrent input beat is not emitted.
- SKID=0 with `out_ready` toggling 1,0,1,0 → `in_ready` tracks `!out_valid || out_ready` combinationally. Every accepted beat is emitted exactly once.
- Assert `rst` asynchronously between edges while FULL → outputs go to reset values immediately, without waiting for `clk`.
- CNT_W=4 with `out_ready`=0 for 20 cycles → `stall_cycles` saturates at 15.
